// File: rtl/alu_pipe.sv
`default_nettype none
// alu_pipe: valid/ready ALU with registered result and flags, plus an
// iterative shift-add multiplier that holds off new operands while it runs.
module alu_pipe #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             overflow
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [SHW-1:0]     count;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;

  logic               out_free;
  logic               accept;
  logic               pop;
  logic               is_mul;
  logic               load_alu;
  logic               load_mul;
  logic               start_mul;
  logic               step_mul;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;

  // Output register can take a new value if empty or being drained this cycle.
  assign out_free = !out_valid || out_ready;
  assign in_ready = !rst && (state == ST_IDLE) && out_free;
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign is_mul   = (sel == OP_MUL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && is_mul)     state_nxt = ST_MUL;
      ST_MUL:  if (count == LAST_ITER)   state_nxt = ST_DONE;
      ST_DONE: if (out_free)             state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    start_mul = 1'b0;
    step_mul  = 1'b0;
    case (state)
      ST_IDLE: begin
        load_alu  = accept && !is_mul;
        start_mul = accept && is_mul;
      end
      ST_MUL:  step_mul = 1'b1;
      ST_DONE: load_mul = out_free;
      default: ;
    endcase
  end

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (sel)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Extended-width difference wraps into bit WIDTH exactly when a < b.
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // Shift-add multiplier: one multiplier bit consumed per MUL cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (start_mul) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      count  <= '0;
    end else if (step_mul) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load_alu) begin
      out       <= alu_res;
      zero      <= (alu_res == '0);
      neg       <= alu_res[WIDTH-1];
      carry     <= alu_c;
      overflow  <= alu_v;
      out_valid <= 1'b1;
    end else if (load_mul) begin
      out       <= acc[WIDTH-1:0];
      zero      <= (acc[WIDTH-1:0] == '0);
      neg       <= acc[WIDTH-1];
      carry     <= 1'b0;
      overflow  <= |acc[2*WIDTH-1:WIDTH];
      out_valid <= 1'b1;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// tb_alu_pipe: directed and randomized checks of alu_pipe against an
// arithmetic reference model and a result queue.
module tb_alu_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   sel = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out;
  logic         zero, neg, carry, overflow;
  logic [35:0]  got;

  int checks   = 0;
  int failures = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero), .neg(neg), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Result packed as {out, zero, neg, carry, overflow}.
  assign got = {out, zero, neg, carry, overflow};

  function automatic logic [35:0] model(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    logic        c, v;
    longint      sa, sb, t;
    logic [63:0] p;
    int          sh;
    r = '0; c = 1'b0; v = 1'b0;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    sh = int'(y % 32);
    case (s)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: r = x ^ y;
      4'd3: begin
        p = 64'(x) + 64'(y); r = p[31:0]; c = p[32];
        t = sa + sb; v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd4: begin
        r = x - y; c = (x < y);
        t = sa - sb; v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd6: r = (x < y) ? 32'd1 : 32'd0;
      4'd7: r = x << sh;
      4'd8: r = x >> sh;
      4'd9: begin t = sa >>> sh; r = t[31:0]; end
      4'd10: begin p = 64'(x) * 64'(y); r = p[31:0]; v = (p[63:32] != 0); end
      default: r = '0;
    endcase
    return {r, (r == 0), r[31], c, v};
  endfunction

  logic [3:0]  d_sel [7] = '{4'd3, 4'd4, 4'd4, 4'd9, 4'd5, 4'd6, 4'd12};
  logic [31:0] d_a   [7] = '{32'h7FFFFFFF, 32'd5, 32'd3, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678};
  logic [31:0] d_b   [7] = '{32'd1, 32'd7, 32'd3, 32'h00000024, 32'd1, 32'd1, 32'h9ABCDEF0};
  logic [35:0] d_exp [7] = '{{32'h80000000, 4'b0101}, {32'hFFFFFFFE, 4'b0110}, {32'h0, 4'b1000},
                             {32'hF8000000, 4'b0100}, {32'h1, 4'b0000}, {32'h0, 4'b1000},
                             {32'h0, 4'b1000}};

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; sel = 4'd3; a = 32'd1; b = 32'd1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || got !== 36'h0) begin
      failures++;
      $display("FAIL reset_state in_ready=%b out_valid=%b got=%h want 0 0 0", in_ready, out_valid, got);
    end
    in_valid = 1'b0; rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b want 1", in_ready);
    end
  endtask

  task automatic test_directed;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; sel = d_sel[i]; a = d_a[i]; b = d_b[i];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL directed_ready[%0d] got=%b want 1", i, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || got !== d_exp[i]) begin
        failures++;
        $display("FAIL directed_op[%0d] sel=%h valid=%b got=%h want %h", i, d_sel[i], out_valid, got, d_exp[i]);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL directed_drain out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0; in_valid = 1'b1; sel = 4'd3; a = 32'd1; b = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b1; sel = 4'd2; a = 32'hF0; b = 32'hFF;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || got !== {32'd3, 4'b0000} || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold[%0d] valid=%b got=%h in_ready=%b want 1 %h 0", k, out_valid, got, in_ready, {32'd3, 4'b0000});
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release_ready got=%b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || got !== {32'h0F, 4'b0000}) begin
      failures++;
      $display("FAIL backpressure_pop_accept valid=%b got=%h want 1 %h", out_valid, got, {32'h0F, 4'b0000});
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_drain out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_mul(input logic [31:0] x, input logic [31:0] y, input logic [35:0] exp_v);
    int low;
    bit early;
    out_ready = 1'b1; in_valid = 1'b1; sel = 4'd10; a = x; b = y;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mul_ready_before got=%b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    low = 0; early = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      if (in_ready === 1'b0) low++;
      if (out_valid !== 1'b0) early = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (low != 33 || early) begin
      failures++;
      $display("FAIL mul_busy a=%h b=%h ready_low_cycles=%0d early_valid=%b want 33 0", x, y, low, early);
    end
    checks++;
    if (out_valid !== 1'b1 || got !== exp_v) begin
      failures++;
      $display("FAIL mul_result a=%h b=%h valid=%b got=%h want 1 %h", x, y, out_valid, got, exp_v);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [35:0] q[$];
    logic [35:0] pend;
    int          busy;
    bit          acc_now, pop_now, exp_ready;
    busy = 0; pend = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (cyc < 450) begin
        in_valid  = ($urandom % 10) < 7;
        out_ready = ($urandom % 10) < 7;
        sel = 4'($urandom_range(0, 15));
        a = $urandom;
        b = (($urandom % 4) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      #1;
      exp_ready = (busy == 0) && (q.size() == 0 || out_ready);
      checks++;
      if (in_ready !== exp_ready || out_valid !== (q.size() != 0)) begin
        failures++;
        $display("FAIL random_handshake cyc=%0d in_ready=%b out_valid=%b want %b %b", cyc, in_ready, out_valid, exp_ready, (q.size() != 0));
      end
      if (q.size() != 0) begin
        checks++;
        if (got !== q[0]) begin
          failures++;
          $display("FAIL random_result cyc=%0d got=%h want %h", cyc, got, q[0]);
        end
      end
      acc_now = in_valid && exp_ready;
      pop_now = (q.size() != 0) && out_ready;
      @(posedge clk); #1;
      if (pop_now) void'(q.pop_front());
      if (busy > 0) begin
        busy--;
        if (busy == 0) q.push_back(pend);
      end
      if (acc_now) begin
        if (sel == 4'd10) begin
          busy = 33;
          pend = model(sel, a, b);
        end else begin
          q.push_back(model(sel, a, b));
        end
      end
    end
  endtask

  task automatic test_reset_mid_mul;
    bit seen;
    out_ready = 1'b1; in_valid = 1'b1; sel = 4'd3; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    sel = 4'd10; a = 32'd3; b = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out !== 32'd10 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmul_pre out=%h valid=%b want 0000000a 0", out, out_valid);
    end
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || got !== 36'h0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmul_async valid=%b got=%h in_ready=%b want 0 0 0", out_valid, got, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmul_ready_after got=%b want 1", in_ready);
    end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL rstmul_stale_result out_valid went high after aborted MUL, want never");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_mul(32'd7, 32'd6, {32'd42, 4'b0000});
    test_mul(32'h00010000, 32'h00010000, {32'h0, 4'b1001});
    test_random();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
